config_chain_segment: RTL and testbench
=======================================

Name: config_chain_segment

Overview:
- Parametrised, double-buffered configuration shift segment for FPGA tiles; successor of the single-bit, single-buffer tile config register.
- Shifts LANES bits per cycle into a WIDTH-bit shadow chain and forwards its oldest bits to the next tile's segment.
- Transfers the shadow chain to the active config output only on an explicit commit, so tile logic never sees partially shifted configuration.
- Tracks fill level and flags misuse (commit before a full load).

Parameters:
- WIDTH, 24, configuration bits held by the segment; must be a multiple of LANES.
- LANES, 1, serial lanes shifted per cycle (1, 2, 4 or 8).
- SHIFTS, WIDTH/LANES, derived (localparam): shifts needed for a full load.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  shift strobe: one LANES-bit shift per cycle while high.
- data_in  in  LANES  serial data from the previous segment or config controller.
- clear  in  1  synchronous clear of the shadow chain and fill state.
- commit  in  1  single-cycle strobe: copy the shadow chain to config_out.
- chain_out  out  LANES  shadow[WIDTH-1 -: LANES], cascades to the next segment.
- config_out  out  WIDTH  active configuration driving tile logic.
- loaded  out  1  high when at least SHIFTS shifts have occurred since the last clear, commit or reset.
- commit_error  out  1  sticky: a commit arrived while not loaded.

Behaviour:
- Reset (asynchronous, active-high): shadow=0, config_out=0, count=0, state=EMPTY, loaded=0, commit_error=0, chain_out=0.
- Shift: when enable=1, shadow <= {shadow[WIDTH-LANES-1:0], data_in}. data_in[LANES-1] is the most recent MSB-side bit. With LANES=WIDTH, shadow <= data_in.
- chain_out is combinational from shadow; zero added latency. A bit entering at shift k exits chain_out after SHIFTS further shifts.
- Counter: counts shifts. It saturates at SHIFTS, and extra shifts are legal pass-through for downstream segments.
- FSM:
  - EMPTY: count=0. enable moves to FILLING, or to LOADED if SHIFTS=1.
  - FILLING: moves to LOADED when count reaches SHIFTS.
  - LOADED: holds until a commit or clear.
  - loaded = (state==LOADED), registered.
- Commit, when loaded=1: config_out <= pre-shift shadow (the value before any same-cycle shift). Then:
  - count <= 0 and state EMPTY if enable=0.
  - count <= 1 and state FILLING (LOADED if SHIFTS=1) if enable=1; the same-cycle shift still happens.
- Commit, when loaded=0: config_out is unchanged and commit_error <= 1. Shadow and count behave as if no commit occurred.
- commit_error clears only on reset.
- clear: shadow <= 0, count <= 0, state EMPTY. config_out and commit_error are untouched. A same-cycle enable is ignored.
- Priority: reset > clear > commit/shift. clear+commit in the same cycle: commit is ignored and no error is raised.
- Reset asserted mid-load or mid-commit: all state returns to reset values immediately. The next load starts from count 0.
- config_out changes only on a successful commit or on reset.

Test Plan:
- WIDTH=24, LANES=1: shift 0xA5C3F1 MSB-first (24 cycles) -> loaded=1 after the 24th shift; config_out stays 0. Commit -> config_out=0xA5C3F1 next cycle, loaded=0.
- WIDTH=24, LANES=2: 12 shifts of pattern 2'b10 -> shadow=0xAAAAAA and loaded=1. Continue 4 shifts of 2'b01 -> chain_out emits 2'b10 four times, loaded stays 1, count saturated.
- Commit after 11 of 12 shifts (LANES=2) -> commit_error=1, config_out unchanged. One more shift then commit -> success; commit_error remains 1.
- Commit and enable in the same cycle after a full load of 0x123456 (LANES=1) with data_in=1 -> config_out=0x123456, shadow=0x2468AD, count=1, state FILLING.
- clear and commit together while loaded -> no commit, commit_error=0, shadow=0, loaded=0, config_out holds its prior value.
- Assert reset asynchronously (between clock edges) after 10 shifts, with config_out=0xFFFFFF -> all outputs 0 immediately. After release, 24 shifts are needed before loaded=1.

Source files
------------

// File: rtl/config_chain_segment_if.sv
// ------------------------------------------------------------------
// config_chain_segment_if : shift/commit bus of a config chain segment
// Revision 1.0
// ------------------------------------------------------------------
`default_nettype none

interface config_chain_segment_if #(
  parameter int WIDTH = 24,
  parameter int LANES = 1
);
  logic             enable;
  logic [LANES-1:0] data_in;
  logic             clear;
  logic             commit;
  logic [LANES-1:0] chain_out;
  logic [WIDTH-1:0] config_out;
  logic             loaded;
  logic             commit_error;

  modport master (
    output enable, data_in, clear, commit,
    input  chain_out, config_out, loaded, commit_error
  );

  modport slave (
    input  enable, data_in, clear, commit,
    output chain_out, config_out, loaded, commit_error
  );
endinterface

`default_nettype wire

// File: rtl/config_chain_segment.sv
// ------------------------------------------------------------------
// config_chain_segment : double-buffered LANES-wide config shift segment
// Revision 1.0
// ------------------------------------------------------------------
`default_nettype none

module config_chain_segment #(
  parameter int WIDTH = 24,
  parameter int LANES = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  config_chain_segment_if.slave  bus
);

  localparam int SHIFTS = WIDTH / LANES;
  localparam int CW     = $clog2(SHIFTS + 1);
  localparam logic [CW-1:0] SHIFTS_C = CW'(SHIFTS);
  localparam logic [CW-1:0] ONE_C    = CW'(1);

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    LOADED  = 2'd2
  } state_t;

  // A single-shift segment is full after its very first shift.
  localparam state_t FIRST_STATE = (SHIFTS == 1) ? LOADED : FILLING;

  state_t           r_state, w_state_next;
  logic [CW-1:0]    r_count, w_count_next;
  logic [WIDTH-1:0] r_shadow, w_shadow_next, w_shifted;
  logic [WIDTH-1:0] r_config, w_config_next;
  logic             r_error, w_error_next;
  logic             w_do_commit;

  generate
    if (LANES == WIDTH) begin : g_full_lane
      assign w_shifted = bus.data_in;
    end else begin : g_partial_lane
      assign w_shifted = {r_shadow[WIDTH-LANES-1:0], bus.data_in};
    end
  endgenerate

  assign w_do_commit = bus.commit & ~bus.clear & (r_state == LOADED);

  always_comb begin
    w_state_next  = r_state;
    w_count_next  = r_count;
    w_shadow_next = r_shadow;
    w_config_next = r_config;
    w_error_next  = r_error;

    if (bus.clear) begin
      w_shadow_next = '0;
      w_count_next  = '0;
      w_state_next  = EMPTY;
    end else begin
      if (bus.enable) begin
        w_shadow_next = w_shifted;
      end

      if (w_do_commit) begin
        // Active config takes the pre-shift shadow; a same-cycle shift starts the next load.
        w_config_next = r_shadow;
        if (bus.enable) begin
          w_count_next = ONE_C;
          w_state_next = FIRST_STATE;
        end else begin
          w_count_next = '0;
          w_state_next = EMPTY;
        end
      end else begin
        if (bus.commit) begin
          w_error_next = 1'b1;
        end
        if (bus.enable && (r_count != SHIFTS_C)) begin
          w_count_next = r_count + ONE_C;
        end
        case (r_state)
          EMPTY: begin
            if (bus.enable) begin
              w_state_next = FIRST_STATE;
            end
          end
          FILLING: begin
            if (bus.enable && ((r_count + ONE_C) == SHIFTS_C)) begin
              w_state_next = LOADED;
            end
          end
          default: begin
            w_state_next = r_state;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= EMPTY;
      r_count  <= '0;
      r_shadow <= '0;
      r_config <= '0;
      r_error  <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_count  <= w_count_next;
      r_shadow <= w_shadow_next;
      r_config <= w_config_next;
      r_error  <= w_error_next;
    end
  end

  assign bus.chain_out    = r_shadow[WIDTH-1 -: LANES];
  assign bus.config_out   = r_config;
  assign bus.loaded       = (r_state == LOADED);
  assign bus.commit_error = r_error;

endmodule

`default_nettype wire

// File: tb/tb_config_chain_segment.sv
// ------------------------------------------------------------------
// tb_config_chain_segment : self-checking bench for LANES=1 and LANES=2 segments
// Revision 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_config_chain_segment;

  logic clock;
  logic reset;
  int   tests;
  int   fails;

  config_chain_segment_if #(.WIDTH(24), .LANES(1)) ifa ();
  config_chain_segment_if #(.WIDTH(24), .LANES(2)) ifb ();

  config_chain_segment #(.WIDTH(24), .LANES(1)) dut_a (.clock(clock), .reset(reset), .bus(ifa));
  config_chain_segment #(.WIDTH(24), .LANES(2)) dut_b (.clock(clock), .reset(reset), .bus(ifb));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Behavioural model: shadow as a 24-bit value, fill level as a saturating shift count.
  typedef struct {
    logic [23:0] shadow;
    logic [23:0] cfg;
    int          count;
    bit          err;
  } model_t;

  model_t ma, mb;

  function automatic model_t model_zero();
    model_t z;
    z.shadow = '0; z.cfg = '0; z.count = 0; z.err = 1'b0;
    return z;
  endfunction

  function automatic model_t model_next(model_t m, int lanes, bit en, logic [1:0] d, bit clr, bit cmt);
    model_t n = m;
    int shifts = 24 / lanes;
    bit full = (m.count >= shifts);
    if (clr) begin
      n.shadow = '0;
      n.count  = 0;
      return n;
    end
    if (cmt && full) begin
      n.cfg   = m.shadow;
      n.count = en ? 1 : 0;
    end else begin
      if (cmt) n.err = 1'b1;
      if (en) n.count = (m.count + 1 > shifts) ? shifts : m.count + 1;
    end
    if (en) n.shadow = (lanes == 1) ? {m.shadow[22:0], d[0]} : {m.shadow[21:0], d};
    return n;
  endfunction

  task automatic idle_inputs();
    ifa.enable = 1'b0; ifa.data_in = '0; ifa.clear = 1'b0; ifa.commit = 1'b0;
    ifb.enable = 1'b0; ifb.data_in = '0; ifb.clear = 1'b0; ifb.commit = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ma = model_zero();
    mb = model_zero();
    @(posedge clock); #3;
    reset = 1'b0;
  endtask

  task automatic drive_a(bit en, bit d, bit clr, bit cmt);
    ifa.enable = en; ifa.data_in = d; ifa.clear = clr; ifa.commit = cmt;
    ma = model_next(ma, 1, en, {1'b0, d}, clr, cmt);
    @(posedge clock); #1;
    idle_inputs();
  endtask

  task automatic drive_b(bit en, logic [1:0] d, bit clr, bit cmt);
    ifb.enable = en; ifb.data_in = d; ifb.clear = clr; ifb.commit = cmt;
    mb = model_next(mb, 2, en, d, clr, cmt);
    @(posedge clock); #1;
    idle_inputs();
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (ifa.config_out !== 24'h0) begin fails++; $display("FAIL reset_cfg_a: got %h expected 000000", ifa.config_out); end
    tests++; if (ifa.chain_out !== 1'b0) begin fails++; $display("FAIL reset_chain_a: got %b expected 0", ifa.chain_out); end
    tests++; if (ifa.loaded !== 1'b0) begin fails++; $display("FAIL reset_loaded_a: got %b expected 0", ifa.loaded); end
    tests++; if (ifa.commit_error !== 1'b0) begin fails++; $display("FAIL reset_err_a: got %b expected 0", ifa.commit_error); end
    tests++; if (ifb.config_out !== 24'h0) begin fails++; $display("FAIL reset_cfg_b: got %h expected 000000", ifb.config_out); end
    tests++; if (ifb.chain_out !== 2'b00) begin fails++; $display("FAIL reset_chain_b: got %b expected 00", ifb.chain_out); end
    tests++; if (ifb.loaded !== 1'b0) begin fails++; $display("FAIL reset_loaded_b: got %b expected 0", ifb.loaded); end
  endtask

  task automatic test_serial_load();
    logic [23:0] pat;
    pat = 24'hA5C3F1;
    do_reset();
    for (int i = 0; i < 24; i++) begin
      drive_a(1'b1, pat[23-i], 1'b0, 1'b0);
      tests++; if (ifa.loaded !== (i == 23)) begin fails++; $display("FAIL serial_loaded shift %0d: got %b expected %b", i, ifa.loaded, (i == 23)); end
      tests++; if (ifa.config_out !== 24'h0) begin fails++; $display("FAIL serial_cfg_hold shift %0d: got %h expected 000000", i, ifa.config_out); end
    end
    tests++; if (ifa.chain_out !== 1'b1) begin fails++; $display("FAIL serial_chain_msb: got %b expected 1", ifa.chain_out); end
    drive_a(1'b0, 1'b0, 1'b0, 1'b1);
    tests++; if (ifa.config_out !== 24'hA5C3F1) begin fails++; $display("FAIL serial_commit_cfg: got %h expected a5c3f1", ifa.config_out); end
    tests++; if (ifa.loaded !== 1'b0) begin fails++; $display("FAIL serial_commit_loaded: got %b expected 0", ifa.loaded); end
    tests++; if (ifa.commit_error !== 1'b0) begin fails++; $display("FAIL serial_commit_err: got %b expected 0", ifa.commit_error); end
  endtask

  task automatic test_lane_saturation();
    do_reset();
    for (int i = 0; i < 12; i++) begin
      drive_b(1'b1, 2'b10, 1'b0, 1'b0);
      tests++; if (ifb.loaded !== (i == 11)) begin fails++; $display("FAIL lane_loaded shift %0d: got %b expected %b", i, ifb.loaded, (i == 11)); end
    end
    for (int i = 0; i < 4; i++) begin
      tests++; if (ifb.chain_out !== 2'b10) begin fails++; $display("FAIL lane_chain_out extra %0d: got %b expected 10", i, ifb.chain_out); end
      drive_b(1'b1, 2'b01, 1'b0, 1'b0);
      tests++; if (ifb.loaded !== 1'b1) begin fails++; $display("FAIL lane_saturated_loaded extra %0d: got %b expected 1", i, ifb.loaded); end
    end
    drive_b(1'b0, 2'b00, 1'b0, 1'b1);
    tests++; if (ifb.config_out !== 24'hAAAA55) begin fails++; $display("FAIL lane_commit_cfg: got %h expected aaaa55", ifb.config_out); end
    tests++; if (ifb.loaded !== 1'b0) begin fails++; $display("FAIL lane_commit_loaded: got %b expected 0", ifb.loaded); end
  endtask

  task automatic test_early_commit();
    do_reset();
    for (int i = 0; i < 11; i++) drive_b(1'b1, 2'($urandom_range(0, 3)), 1'b0, 1'b0);
    drive_b(1'b0, 2'b00, 1'b0, 1'b1);
    tests++; if (ifb.commit_error !== 1'b1) begin fails++; $display("FAIL early_commit_err: got %b expected 1", ifb.commit_error); end
    tests++; if (ifb.config_out !== 24'h0) begin fails++; $display("FAIL early_commit_cfg: got %h expected 000000", ifb.config_out); end
    tests++; if (ifb.loaded !== 1'b0) begin fails++; $display("FAIL early_commit_loaded: got %b expected 0", ifb.loaded); end
    drive_b(1'b1, 2'($urandom_range(0, 3)), 1'b0, 1'b0);
    tests++; if (ifb.loaded !== 1'b1) begin fails++; $display("FAIL early_final_loaded: got %b expected 1", ifb.loaded); end
    drive_b(1'b0, 2'b00, 1'b0, 1'b1);
    tests++; if (ifb.config_out !== mb.cfg) begin fails++; $display("FAIL early_late_commit_cfg: got %h expected %h", ifb.config_out, mb.cfg); end
    tests++; if (ifb.commit_error !== 1'b1) begin fails++; $display("FAIL early_err_sticky: got %b expected 1", ifb.commit_error); end
  endtask

  task automatic test_commit_with_shift();
    logic [23:0] pat;
    logic [23:0] rec;
    pat = 24'h123456;
    rec = '0;
    do_reset();
    for (int i = 0; i < 24; i++) drive_a(1'b1, pat[23-i], 1'b0, 1'b0);
    drive_a(1'b1, 1'b1, 1'b0, 1'b1);
    tests++; if (ifa.config_out !== 24'h123456) begin fails++; $display("FAIL cws_cfg: got %h expected 123456", ifa.config_out); end
    tests++; if (ifa.loaded !== 1'b0) begin fails++; $display("FAIL cws_loaded: got %b expected 0", ifa.loaded); end
    for (int i = 0; i < 24; i++) begin
      rec = {rec[22:0], ifa.chain_out};
      drive_a(1'b1, 1'b0, 1'b0, 1'b0);
      tests++; if (ifa.loaded !== (i >= 22)) begin fails++; $display("FAIL cws_refill_loaded shift %0d: got %b expected %b", i, ifa.loaded, (i >= 22)); end
    end
    tests++; if (rec !== 24'h2468AD) begin fails++; $display("FAIL cws_shadow: got %h expected 2468ad", rec); end
  endtask

  task automatic test_clear_commit();
    logic [23:0] val;
    do_reset();
    val = 24'($urandom);
    for (int i = 0; i < 24; i++) drive_a(1'b1, val[23-i], 1'b0, 1'b0);
    drive_a(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 24; i++) drive_a(1'b1, 1'($urandom), 1'b0, 1'b0);
    drive_a(1'b1, 1'b1, 1'b1, 1'b1);
    tests++; if (ifa.config_out !== val) begin fails++; $display("FAIL clrcmt_cfg: got %h expected %h", ifa.config_out, val); end
    tests++; if (ifa.commit_error !== 1'b0) begin fails++; $display("FAIL clrcmt_err: got %b expected 0", ifa.commit_error); end
    tests++; if (ifa.loaded !== 1'b0) begin fails++; $display("FAIL clrcmt_loaded: got %b expected 0", ifa.loaded); end
    tests++; if (ifa.chain_out !== 1'b0) begin fails++; $display("FAIL clrcmt_chain: got %b expected 0", ifa.chain_out); end
    for (int i = 0; i < 24; i++) begin
      drive_a(1'b1, 1'b1, 1'b0, 1'b0);
      tests++; if (ifa.loaded !== (i == 23)) begin fails++; $display("FAIL clrcmt_reload shift %0d: got %b expected %b", i, ifa.loaded, (i == 23)); end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    drive_a(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 24; i++) drive_a(1'b1, 1'b1, 1'b0, 1'b0);
    drive_a(1'b0, 1'b0, 1'b0, 1'b1);
    tests++; if (ifa.config_out !== 24'hFFFFFF) begin fails++; $display("FAIL areset_pre_cfg: got %h expected ffffff", ifa.config_out); end
    for (int i = 0; i < 10; i++) drive_a(1'b1, 1'b1, 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    ma = model_zero();
    mb = model_zero();
    #1;
    tests++; if (ifa.config_out !== 24'h0) begin fails++; $display("FAIL areset_cfg: got %h expected 000000", ifa.config_out); end
    tests++; if (ifa.chain_out !== 1'b0) begin fails++; $display("FAIL areset_chain: got %b expected 0", ifa.chain_out); end
    tests++; if (ifa.commit_error !== 1'b0) begin fails++; $display("FAIL areset_err: got %b expected 0", ifa.commit_error); end
    #1;
    reset = 1'b0;
    for (int i = 0; i < 24; i++) begin
      drive_a(1'b1, 1'b1, 1'b0, 1'b0);
      tests++; if (ifa.loaded !== (i == 23)) begin fails++; $display("FAIL areset_reload shift %0d: got %b expected %b", i, ifa.loaded, (i == 23)); end
    end
  endtask

  task automatic test_random();
    bit ena, da, ca, ka, enb, cb, kb;
    logic [1:0] db;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      ena = ($urandom_range(0, 3) != 0); da = 1'($urandom);
      ca  = ($urandom_range(0, 40) == 0); ka = ($urandom_range(0, 12) == 0);
      enb = ($urandom_range(0, 3) != 0); db = 2'($urandom);
      cb  = ($urandom_range(0, 40) == 0); kb = ($urandom_range(0, 12) == 0);
      ifa.enable = ena; ifa.data_in = da; ifa.clear = ca; ifa.commit = ka;
      ifb.enable = enb; ifb.data_in = db; ifb.clear = cb; ifb.commit = kb;
      ma = model_next(ma, 1, ena, {1'b0, da}, ca, ka);
      mb = model_next(mb, 2, enb, db, cb, kb);
      @(posedge clock); #1;
      idle_inputs();
      tests++; if (ifa.config_out !== ma.cfg) begin fails++; $display("FAIL rand_cfg_a cyc %0d: got %h expected %h", n, ifa.config_out, ma.cfg); end
      tests++; if (ifa.chain_out !== ma.shadow[23]) begin fails++; $display("FAIL rand_chain_a cyc %0d: got %b expected %b", n, ifa.chain_out, ma.shadow[23]); end
      tests++; if (ifa.loaded !== (ma.count >= 24)) begin fails++; $display("FAIL rand_loaded_a cyc %0d: got %b expected %b", n, ifa.loaded, (ma.count >= 24)); end
      tests++; if (ifa.commit_error !== ma.err) begin fails++; $display("FAIL rand_err_a cyc %0d: got %b expected %b", n, ifa.commit_error, ma.err); end
      tests++; if (ifb.config_out !== mb.cfg) begin fails++; $display("FAIL rand_cfg_b cyc %0d: got %h expected %h", n, ifb.config_out, mb.cfg); end
      tests++; if (ifb.chain_out !== mb.shadow[23:22]) begin fails++; $display("FAIL rand_chain_b cyc %0d: got %b expected %b", n, ifb.chain_out, mb.shadow[23:22]); end
      tests++; if (ifb.loaded !== (mb.count >= 12)) begin fails++; $display("FAIL rand_loaded_b cyc %0d: got %b expected %b", n, ifb.loaded, (mb.count >= 12)); end
      tests++; if (ifb.commit_error !== mb.err) begin fails++; $display("FAIL rand_err_b cyc %0d: got %b expected %b", n, ifb.commit_error, mb.err); end
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_serial_load();
    test_lane_saturation();
    test_early_commit();
    test_commit_with_shift();
    test_clear_commit();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
